iir_biquad_mc: RTL and testbench
================================

# iir_biquad_mc

Time-multiplexed multi-channel 2nd-order IIR (biquad) filter for the audio output path. One shared multiplier evaluates the difference equation for every channel in turn, once per sample tick (clk/div). Outputs use round-to-nearest and saturation instead of truncation. A per-block bypass mode is provided. All channel outputs update together on one cycle, flagged by a strobe.

## Interface
- CHANNELS, 2: number of independent filter channels sharing the coefficients.
- DATA_WIDTH, 16: signed sample width.
- COEFF_WIDTH, 18: signed coefficient width.
- COEFF_SCALE, 14: coefficient fraction bits (1.0 = 2^COEFF_SCALE).
- COUNT_BITS, 10: sample divider width.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- div  in  COUNT_BITS  sample period in clk cycles; 0 disables ticks.
- A2, A3, B1, B2, B3  in  COEFF_WIDTH each  signed coefficients, shared by all channels.
- bypass  in  1  1 = output equals input, no filtering.
- in  in  CHANNELS*DATA_WIDTH  signed samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- out  out  CHANNELS*DATA_WIDTH  filtered samples, same packing.
- out_stb  out  1  one-cycle pulse on the cycle `out` updates.
- busy  out  1  high while the MAC sequence runs.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.

## Operation
- Equation per channel: y = (B1·x + B2·x1 + B3·x2 − A2·y1 − A3·y2) / 2^COEFF_SCALE.
  - x is the new input; x1/x2 are past inputs; y1/y2 are past outputs.
- Divider: count increments every cycle. When count == div−1, count returns to 0 and a tick is raised. When div == 0, no ticks occur and count holds at 0.
- FSM states: IDLE, MAC, WRITE.
- IDLE, on tick:
  - Latch all `in` lanes into in_lat.
  - Set ch = 0 and step = 0.
  - Load acc with the rounding constant 2^(COEFF_SCALE−1).
  - Go to MAC.
- MAC, steps 0..4, one product per cycle:
  - Step 0 adds B1·in_lat[ch].
  - Step 1 adds B2·x1[ch].
  - Step 2 adds B3·x2[ch].
  - Step 3 subtracts A2·y1[ch].
  - Step 4 subtracts A3·y2[ch].
  - After step 4, go to WRITE.
- WRITE:
  - Compute r = acc >>> COEFF_SCALE (arithmetic shift).
  - Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; the saturated value is res.
  - If bypass = 1, res = in_lat[ch].
  - Update history: x2 ← x1, x1 ← in_lat[ch], y2 ← y1, y1 ← res. In bypass the history therefore tracks the input, so leaving bypass gives no transient.
  - Store res in the output staging register for ch.
  - Reload acc with the rounding constant.
  - If ch < CHANNELS−1: ch++, go to MAC step 0.
  - Otherwise: copy staging to `out`, pulse out_stb, go to IDLE.
- Accumulator: DATA_WIDTH+COEFF_WIDTH+3 bits, signed. This is enough for 5 full-scale products with no wrap.
- Coefficients and bypass are sampled live during MAC/WRITE. Software changes them only between ticks; mid-sequence changes give an undefined (but bounded, saturated) sample.
- Overrun: a tick while busy is dropped and pulses overrun. The sequence in progress completes unchanged, and count still resets on the dropped tick.

## Timing
- Reset (asynchronous assert) clears:
  - count, acc, all history, in_lat and staging registers to 0;
  - FSM to IDLE, ch = 0;
  - out = 0, out_stb = 0, busy = 0, overrun = 0.
- Reset asserted mid-sequence aborts it. `out` returns to 0 and no out_stb is issued.
- Reset release is synchronous to the first clk edge with reset_n high.
- Tick at edge T:
  - busy is high from T+1.
  - Each channel takes 6 cycles (5 MAC + 1 WRITE).
  - `out` and out_stb update at edge T+6·CHANNELS; busy falls on the same edge.
  - With CHANNELS = 2, the latency is 12 cycles.
- Minimum div for overrun-free operation: 6·CHANNELS+1.
- out_stb is exactly one cycle wide. `out` is stable between strobes.

## Test plan
- **Reset:** hold reset_n = 0 with nonzero in and div = 20 → out = 0, out_stb/busy/overrun = 0; after release, first out_stb at cycle 20+12.
- **DC step, low-pass:** A2 = −18174, A3 = 6523, B1 = 1183, B2 = 2367, B3 = 1183, in = 10000 on both channels, div = 20 → out converges to 10000 ±2 within 40 ticks; no overshoot above 10300.
- **Channel isolation:** impulse 16000 for one tick on ch0 only, ch1 = 0 → ch1 out stays 0 on every strobe; ch0 first out = (1183·16000 + 8192) >> 14 = 1155.
- **Saturation:** A2 = A3 = 0, B1 = B2 = B3 = 16383, in = 32767 → out = 32767 from the 2nd tick; in = −32768 → out = −32768 with no wrap.
- **Overrun:** div = 8, CHANNELS = 2 → overrun pulses on the tick every other period; out_stb still pulses with correct values.
- **Bypass and reset mid-sequence:**
  - bypass = 1, ramp input → out equals in_lat at every strobe, 12 cycles after each tick.
  - Drop bypass → no step at the next strobe.
  - Assert reset_n at cycle T+7 → no strobe is issued; state is cleared.

Source files
------------

// File: rtl/iir_biquad_mc.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_mc
// Purpose  : Multi-channel 2nd-order IIR (biquad). A single shared multiplier
//            steps through every channel once per sample tick, with rounding,
//            saturation and a bypass mode.
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_mc #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 18,
    parameter int COEFF_SCALE = 14,
    parameter int COUNT_BITS  = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [COUNT_BITS-1:0]             div,
    input  logic signed [COEFF_WIDTH-1:0]     A2,
    input  logic signed [COEFF_WIDTH-1:0]     A3,
    input  logic signed [COEFF_WIDTH-1:0]     B1,
    input  logic signed [COEFF_WIDTH-1:0]     B2,
    input  logic signed [COEFF_WIDTH-1:0]     B3,
    input  logic                              bypass,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    in,
    output logic [CHANNELS*DATA_WIDTH-1:0]    out,
    output logic                              out_stb,
    output logic                              busy,
    output logic                              overrun
);

    localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + 3;
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [ACC_W-1:0] c_ROUND   = ACC_W'(1) << (COEFF_SCALE - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                        r_state;
    logic [COUNT_BITS-1:0]         r_count;
    logic [CH_W-1:0]               r_ch;
    logic [2:0]                    r_step;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [DATA_WIDTH-1:0]  r_in_lat [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_x1     [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_x2     [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_y1     [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_y2     [CHANNELS];
    logic signed [DATA_WIDTH-1:0]  r_stage  [CHANNELS];

    logic                          w_tick;
    logic signed [COEFF_WIDTH-1:0] w_coef;
    logic signed [DATA_WIDTH-1:0]  w_opnd;
    logic                          w_sub;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_W-1:0]       w_prod_ext;
    logic signed [ACC_W-1:0]       w_shift;
    logic signed [DATA_WIDTH-1:0]  w_res;

    assign w_tick = (div != '0) && (r_count == div - COUNT_BITS'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (div == '0 || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + COUNT_BITS'(1);
        end
    end

    // Operand select for the single shared multiplier, one term per MAC step
    always_comb begin
        w_coef = B1;
        w_opnd = r_in_lat[r_ch];
        w_sub  = 1'b0;
        case (r_step)
            3'd0: begin w_coef = B1; w_opnd = r_in_lat[r_ch]; end
            3'd1: begin w_coef = B2; w_opnd = r_x1[r_ch]; end
            3'd2: begin w_coef = B3; w_opnd = r_x2[r_ch]; end
            3'd3: begin w_coef = A2; w_opnd = r_y1[r_ch]; w_sub = 1'b1; end
            default: begin w_coef = A3; w_opnd = r_y2[r_ch]; w_sub = 1'b1; end
        endcase
    end

    assign w_prod     = w_coef * w_opnd;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_comb begin
        w_shift = r_acc >>> COEFF_SCALE;
        if (bypass) begin
            w_res = r_in_lat[r_ch];
        end else if (w_shift > c_SAT_MAX) begin
            w_res = c_SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shift < c_SAT_MIN) begin
            w_res = c_SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_res = w_shift[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_step  <= '0;
            r_acc   <= '0;
            out     <= '0;
            out_stb <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_in_lat[k] <= '0;
                r_x1[k]     <= '0;
                r_x2[k]     <= '0;
                r_y1[k]     <= '0;
                r_y2[k]     <= '0;
                r_stage[k]  <= '0;
            end
        end else begin
            out_stb <= 1'b0;
            // A tick that lands mid-sequence is dropped; the divider has already restarted
            overrun <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            r_in_lat[k] <= in[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_ch    <= '0;
                        r_step  <= '0;
                        r_acc   <= c_ROUND;
                        busy    <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
                    if (r_step == 3'd4) begin
                        r_step  <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_x2[r_ch]    <= r_x1[r_ch];
                    r_x1[r_ch]    <= r_in_lat[r_ch];
                    r_y2[r_ch]    <= r_y1[r_ch];
                    r_y1[r_ch]    <= w_res;
                    r_stage[r_ch] <= w_res;
                    r_acc         <= c_ROUND;
                    if (int'(r_ch) == CHANNELS - 1) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            out[k*DATA_WIDTH +: DATA_WIDTH] <= (k == int'(r_ch)) ? w_res : r_stage[k];
                        end
                        out_stb <= 1'b1;
                        busy    <= 1'b0;
                        r_ch    <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ch    <= CH_W'(int'(r_ch) + 1);
                        r_state <= S_MAC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_mc.sv
`default_nettype none
// Testbench for iir_biquad_mc: randomized stimulus, arithmetic reference model,
// queue-based scoreboard with an independent output monitor.
module tb_iir_biquad_mc;

    localparam int CH  = 2;
    localparam int DW  = 16;
    localparam int LAT = 6 * CH;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [9:0]         div = 10'd20;
    logic signed [17:0] a2, a3, b1, b2, b3;
    logic               bypass = 1'b0;
    logic [31:0]        din = 32'h2710_2710;
    logic [31:0]        out;
    logic               out_stb, busy, overrun;

    always #5 clk = ~clk;

    iir_biquad_mc #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .COEFF_WIDTH(18), .COEFF_SCALE(14), .COUNT_BITS(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .div(div),
        .A2(a2), .A3(a3), .B1(b1), .B2(b2), .B3(b3),
        .bypass(bypass), .in(din), .out(out),
        .out_stb(out_stb), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        int          at;
        logic [31:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          drop_q[$];
    logic [31:0] stb_log[$];
    int          n_cmp = 0, n_fail = 0;
    int          cyc;
    int          la;
    bit          la_valid = 1'b0;
    int          first_at = -1;
    int          n_drop = 0, n_ovr_seen = 0;
    longint      mx1[CH], mx2[CH], my1[CH], my2[CH];
    exp_t        m_it;
    bit          m_ovr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic longint lane(input logic [31:0] v, input int k);
        logic signed [15:0] s;
        s = v[k*16 +: 16];
        return longint'(s);
    endfunction

    task automatic flush();
        exp_q.delete();
        drop_q.delete();
        stb_log.delete();
        la_valid   = 1'b0;
        first_at   = -1;
        n_drop     = 0;
        n_ovr_seen = 0;
        for (int k = 0; k < CH; k++) begin
            mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
        end
    endtask

    // Reference: ticks fall on every div-th edge after reset release; a tick
    // closer than LAT+1 edges to the previous accepted one is dropped.
    task automatic predict();
        int     e;
        longint x, acc, r, res;
        exp_t   it;
        if (!reset_n || div == 10'd0) return;
        e = cyc + 1;
        if (e % int'(div) != 0) return;
        if (la_valid && e < la + LAT + 1) begin
            drop_q.push_back(e);
            n_drop++;
            return;
        end
        la = e;
        la_valid = 1'b1;
        it.v = '0;
        for (int k = 0; k < CH; k++) begin
            x   = lane(din, k);
            acc = longint'(b1) * x + longint'(b2) * mx1[k] + longint'(b3) * mx2[k]
                - longint'(a2) * my1[k] - longint'(a3) * my2[k];
            r   = (acc + 8192) >>> 14;
            if (r > 32767)       r = 32767;
            else if (r < -32768) r = -32768;
            res = bypass ? x : r;
            mx2[k] = mx1[k]; mx1[k] = x;
            my2[k] = my1[k]; my1[k] = res;
            it.v[k*16 +: 16] = res[15:0];
        end
        it.at = e + LAT;
        exp_q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            m_ovr = 1'b0;
            if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                m_ovr = 1'b1;
                void'(drop_q.pop_front());
            end
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, (la_valid && cyc >= la && cyc < la + LAT) ? 1 : 0);
            if (overrun) n_ovr_seen++;
            if (out_stb || (exp_q.size() > 0 && exp_q[0].at <= cyc)) begin
                if (exp_q.size() == 0) begin
                    chk("stb_unexpected", 1, 0);
                end else begin
                    m_it = exp_q.pop_front();
                    chk("stb_present", out_stb, 1);
                    chk("stb_time", cyc, m_it.at);
                    chk("stb_data", out, m_it.v);
                end
                if (out_stb) begin
                    stb_log.push_back(out);
                    if (first_at < 0) first_at = cyc;
                end
            end
        end
    end

    task automatic step(input logic [31:0] d);
        @(negedge clk);
        din = d;
        predict();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        flush();
        repeat (3) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_stb", out_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        predict();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() > 0 && g < 400) begin
            step(din);
            g++;
        end
        step(din);
        chk("idle_reached", exp_q.size(), 0);
    endtask

    task automatic set_lp();
        a2 = -18'sd18174; a3 = 18'sd6523;
        b1 = 18'sd1183;   b2 = 18'sd2367; b3 = 18'sd1183;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint      v;
        int          nz;
        int          g;
        logic [31:0] cst;

        set_lp();
        // Reset with nonzero inputs, then DC step on both channels
        do_reset();
        repeat (799) step(32'h2710_2710);
        wait_idle();
        chk("first_stb_cycle", first_at, 20 + LAT);
        chk("dc_strobes", stb_log.size(), 40);
        if (stb_log.size() >= 40) begin
            for (int k = 0; k < CH; k++) begin
                v = lane(stb_log[39], k) - 10000;
                chk("dc_converged", (v >= -2 && v <= 2) ? 1 : 0, 1);
            end
        end

        // Impulse on ch0 only
        din = {16'sd0, 16'sd16000};
        do_reset();
        repeat (19) step({16'sd0, 16'sd16000});
        repeat (200) step(32'h0);
        wait_idle();
        chk("impulse_first", (stb_log.size() > 0) ? lane(stb_log[0], 0) : -1, 1155);
        nz = 0;
        foreach (stb_log[i]) if (lane(stb_log[i], 1) != 0) nz++;
        chk("isolation_ch1", nz, 0);

        // Saturation, positive then negative full scale
        a2 = 18'sd0; a3 = 18'sd0;
        b1 = 18'sd16383; b2 = 18'sd16383; b3 = 18'sd16383;
        din = {16'sd32767, 16'sd32767};
        do_reset();
        repeat (60) step({16'sd32767, 16'sd32767});
        wait_idle();
        if (stb_log.size() >= 3) begin
            chk("sat_pos_t2", lane(stb_log[1], 0), 32767);
            chk("sat_pos_t3", lane(stb_log[2], 1), 32767);
        end else chk("sat_pos_count", stb_log.size(), 3);
        repeat (60) step({16'h8000, 16'h8000});
        wait_idle();
        chk("sat_neg_ch0", lane(stb_log[stb_log.size()-1], 0), -32768);
        chk("sat_neg_ch1", lane(stb_log[stb_log.size()-1], 1), -32768);

        // Random inputs through the low-pass, then random coefficients
        set_lp();
        do_reset();
        repeat (600) step($urandom);
        wait_idle();
        a2 = 18'($urandom); a3 = 18'($urandom);
        b1 = 18'($urandom); b2 = 18'($urandom); b3 = 18'($urandom);
        do_reset();
        repeat (400) step($urandom);
        wait_idle();

        // Overrun: period shorter than the MAC sequence
        set_lp();
        div = 10'd8;
        do_reset();
        repeat (200) step($urandom);
        chk("overrun_seen", (n_ovr_seen > 0) ? 1 : 0, 1);
        chk("overrun_count", n_ovr_seen, n_drop);
        div = 10'd20;

        // Bypass with a ramp, then leave bypass on a held input
        bypass = 1'b1;
        do_reset();
        for (int i = 0; i < 200; i++) step({16'(-i * 53), 16'(i * 37)});
        cst = {16'sd1234, -16'sd777};
        repeat (60) step(cst);
        wait_idle();
        bypass = 1'b0;
        repeat (45) step(cst);
        wait_idle();
        chk("unbypass_ch0", lane(stb_log[stb_log.size()-1], 0), -777);
        chk("unbypass_ch1", lane(stb_log[stb_log.size()-1], 1), 1234);

        // Reset asserted in the middle of a sequence
        g = 0;
        do begin
            step($urandom);
            g++;
        end while (!(la_valid && cyc == la + 6) && g < 100);
        chk("midseq_found", (la_valid && cyc == la + 6) ? 1 : 0, 1);
        #2 reset_n = 1'b0;
        flush();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midseq_no_stb", out_stb, 0);
        end
        chk("midseq_out", out, 0);
        chk("midseq_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        predict();
        repeat (100) step($urandom);
        wait_idle();
        chk("drops_pending", drop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
